// File: rtl/pport_pkg.sv
// Shared types and default timing for the peripheral port arbiter/sequencer.
package pport_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT_RDY,
        ST_HOLD
    } state_t;

    typedef enum logic [1:0] {
        SEL_PORT0 = 2'b00,
        SEL_PORT1 = 2'b01,
        SEL_PORT2 = 2'b10,
        SEL_NONE  = 2'b11
    } sel_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam int unsigned SETUP_CYC_DEF   = 1;
    localparam int unsigned STROBE_CYC_DEF  = 3;
    localparam int unsigned HOLD_CYC_DEF    = 1;
    localparam int unsigned TIMEOUT_CYC_DEF = 255;

    // Select vector {CSS, CSX0, CSX1, DACK}; a DMA owner only ever gets DACK.
    function automatic logic [3:0] cs_decode(input owner_t own, input sel_t sel);
        logic [3:0] v;
        v = '0;
        if (own == OWN_DMA) begin
            v[0] = 1'b1;
        end else begin
            case (sel)
                SEL_PORT0: v[3] = 1'b1;
                SEL_PORT1: v[2] = 1'b1;
                SEL_PORT2: v[1] = 1'b1;
                default:   v    = '0;
            endcase
        end
        return v;
    endfunction

endpackage

// File: rtl/pport_timer.sv
// Loadable down-counter; 'expired' is high for the single cycle the count reads 1.
module pport_timer #(
    parameter int unsigned W = 4
) (
    input  logic         SCLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge SCLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == W'(1));

endmodule

// File: rtl/pport_arbiter.sv
// Peripheral port arbiter/sequencer: CPU vs DMA grant, CS/strobe/DACK timing with IORDY.
// Optional IORDY wait abort enabled by defining PPORT_TIMEOUT_EN.
module pport_arbiter
    import pport_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = SETUP_CYC_DEF,
    parameter int unsigned STROBE_CYC  = STROBE_CYC_DEF,
    parameter int unsigned HOLD_CYC    = HOLD_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       SCLK,
    input  logic       RST,
    input  logic       CPU_REQ,
    input  logic       CPU_RW,
    input  logic [1:0] CPU_SEL,
    output logic       CPU_ACK,
    input  logic       DMA_REQ,
    input  logic       DMA_DIR,
    output logic       DMA_ACK,
    input  logic       IORDY,
    output logic       RE_O,
    output logic       WE_O,
    output logic       CSS_O,
    output logic       CSX0_O,
    output logic       CSX1_O,
    output logic       DACK_O,
    output logic       LATCH_O,
    output logic       BUSY,
    output logic       TIMEOUT_O
);

    if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
        $error("pport_arbiter: SETUP_CYC must be 1..15");
    end
    if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe
        $error("pport_arbiter: STROBE_CYC must be 1..15");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
        $error("pport_arbiter: HOLD_CYC must be 1..15");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("pport_arbiter: TIMEOUT_CYC must be 1..255");
    end

    state_t     state;
    owner_t     owner;
    owner_t     last_grant;
    logic       rd;
    logic [3:0] cs_q;
    logic       re_q;
    logic       we_q;

    logic       t_load;
    logic [3:0] t_val;
    logic       t_exp;
    logic       to_exp;

    logic       cpu_win;
    owner_t     grant_own;
    logic       grant_rd;
    logic       strobe_end;
    logic       wait_abort;
    logic       hold_end;

    // Alternate on a tie: the CPU wins only if DMA had the last grant.
    assign cpu_win   = CPU_REQ && (!DMA_REQ || last_grant == OWN_DMA);
    assign grant_own = cpu_win ? OWN_CPU : OWN_DMA;
    assign grant_rd  = cpu_win ? CPU_RW : !DMA_DIR;

    assign strobe_end = (state == ST_STROBE && t_exp && IORDY) ||
                        (state == ST_WAIT_RDY && IORDY);
    assign wait_abort = (state == ST_WAIT_RDY) && !IORDY && to_exp;
    assign hold_end   = (state == ST_HOLD) && t_exp;

    always_comb begin
        t_load = 1'b0;
        t_val  = '0;
        case (state)
            ST_IDLE: begin
                if (CPU_REQ || DMA_REQ) begin
                    t_load = 1'b1;
                    t_val  = 4'(SETUP_CYC);
                end
            end
            ST_SETUP: begin
                if (t_exp) begin
                    t_load = 1'b1;
                    t_val  = 4'(STROBE_CYC);
                end
            end
            ST_STROBE, ST_WAIT_RDY: begin
                if (strobe_end || wait_abort) begin
                    t_load = 1'b1;
                    t_val  = 4'(HOLD_CYC);
                end
            end
            default: begin
                t_load = 1'b0;
                t_val  = '0;
            end
        endcase
    end

    pport_timer #(.W(4)) u_timer (
        .SCLK    (SCLK),
        .RST     (RST),
        .load    (t_load),
        .value   (t_val),
        .expired (t_exp)
    );

`ifdef PPORT_TIMEOUT_EN
    logic to_load;
    assign to_load = (state == ST_STROBE) && t_exp && !IORDY;

    pport_timer #(.W(8)) u_timeout (
        .SCLK    (SCLK),
        .RST     (RST),
        .load    (to_load),
        .value   (8'(TIMEOUT_CYC)),
        .expired (to_exp)
    );
`else
    assign to_exp = 1'b0;
`endif

    always_ff @(posedge SCLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            owner      <= OWN_CPU;
            last_grant <= OWN_CPU;
            rd         <= 1'b0;
            cs_q       <= '0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (CPU_REQ || DMA_REQ) begin
                        owner      <= grant_own;
                        last_grant <= grant_own;
                        rd         <= grant_rd;
                        cs_q       <= cs_decode(grant_own, sel_t'(CPU_SEL));
                        state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (t_exp) begin
                        re_q  <= rd;
                        we_q  <= !rd;
                        state <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (t_exp) begin
                        if (strobe_end) begin
                            re_q  <= 1'b0;
                            we_q  <= 1'b0;
                            state <= ST_HOLD;
                        end else begin
                            state <= ST_WAIT_RDY;
                        end
                    end
                end
                ST_WAIT_RDY: begin
                    if (strobe_end || wait_abort) begin
                        re_q  <= 1'b0;
                        we_q  <= 1'b0;
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (t_exp) begin
                        cs_q  <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    cs_q  <= '0;
                    re_q  <= 1'b0;
                    we_q  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign {CSS_O, CSX0_O, CSX1_O, DACK_O} = cs_q;
    assign RE_O = re_q;
    assign WE_O = we_q;

    // Pulses are decoded from registered state because they depend on same-cycle IORDY.
    assign LATCH_O   = rd && strobe_end;
    assign TIMEOUT_O = wait_abort;
    assign CPU_ACK   = hold_end && (owner == OWN_CPU);
    assign DMA_ACK   = hold_end && (owner == OWN_DMA);
    assign BUSY      = (state != ST_IDLE);

endmodule

// File: tb/tb_pport_arbiter.sv
// Directed self-checking bench for pport_arbiter (default timing and a 2/1/2 instance).
module tb_pport_arbiter;

    logic       SCLK = 1'b0;
    logic       RST, IORDY;
    logic       CPU_REQ, CPU_RW, DMA_REQ, DMA_DIR;
    logic [1:0] CPU_SEL;
    logic       CPU_ACK, DMA_ACK, RE_O, WE_O, CSS_O, CSX0_O, CSX1_O, DACK_O;
    logic       LATCH_O, BUSY, TIMEOUT_O;

    logic       cpu_req2, cpu_rw2, dma_req2, dma_dir2;
    logic [1:0] cpu_sel2;
    logic       cpu_ack2, dma_ack2, re2, we2, css2, csx02, csx12, dack2, latch2, busy2, to2;

    int errors = 0;
    int checks = 0;

    // {BUSY, CPU_ACK, DMA_ACK, LATCH, RE, WE, CSS, CSX0, CSX1, DACK, TIMEOUT}
    logic [10:0] v1, v2;
    assign v1 = {BUSY, CPU_ACK, DMA_ACK, LATCH_O, RE_O, WE_O, CSS_O, CSX0_O, CSX1_O, DACK_O, TIMEOUT_O};
    assign v2 = {busy2, cpu_ack2, dma_ack2, latch2, re2, we2, css2, csx02, csx12, dack2, to2};

    always #5 SCLK = ~SCLK;

    pport_arbiter #(.TIMEOUT_CYC(8)) dut (
        .SCLK(SCLK), .RST(RST), .CPU_REQ(CPU_REQ), .CPU_RW(CPU_RW), .CPU_SEL(CPU_SEL),
        .CPU_ACK(CPU_ACK), .DMA_REQ(DMA_REQ), .DMA_DIR(DMA_DIR), .DMA_ACK(DMA_ACK),
        .IORDY(IORDY), .RE_O(RE_O), .WE_O(WE_O), .CSS_O(CSS_O), .CSX0_O(CSX0_O),
        .CSX1_O(CSX1_O), .DACK_O(DACK_O), .LATCH_O(LATCH_O), .BUSY(BUSY), .TIMEOUT_O(TIMEOUT_O)
    );

    pport_arbiter #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(2)) dut2 (
        .SCLK(SCLK), .RST(RST), .CPU_REQ(cpu_req2), .CPU_RW(cpu_rw2), .CPU_SEL(cpu_sel2),
        .CPU_ACK(cpu_ack2), .DMA_REQ(dma_req2), .DMA_DIR(dma_dir2), .DMA_ACK(dma_ack2),
        .IORDY(IORDY), .RE_O(re2), .WE_O(we2), .CSS_O(css2), .CSX0_O(csx02),
        .CSX1_O(csx12), .DACK_O(dack2), .LATCH_O(latch2), .BUSY(busy2), .TIMEOUT_O(to2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge SCLK);
    endtask

    logic [10:0] exp1 [1:6];
    logic [10:0] exp6 [1:6];
    int          ack_k [8];
    logic        ack_dma [8];
    int          n_ack, we_n, latch_n, csx1_n, ack_at, dack_at, latch_at, to_at;

    initial begin
        exp1 = '{11'b10000010000, 11'b10001010000, 11'b10001010000,
                 11'b10011010000, 11'b11000010000, 11'b00000000000};
        exp6 = '{11'b10000000000, 11'b10000000000, 11'b10011000000,
                 11'b10000000000, 11'b11000000000, 11'b00000000000};

        RST = 1'b1; IORDY = 1'b1;
        CPU_REQ = 1'b0; CPU_RW = 1'b0; CPU_SEL = 2'b00; DMA_REQ = 1'b0; DMA_DIR = 1'b0;
        cpu_req2 = 1'b0; cpu_rw2 = 1'b0; cpu_sel2 = 2'b00; dma_req2 = 1'b0; dma_dir2 = 1'b0;
        tick(); tick(); tick(); #1;
        chk("reset_dut", v1, 11'b0);
        chk("reset_dut2", v2, 11'b0);
        RST = 1'b0;
        tick(); tick();

        // CPU read of port 0, IORDY high
        CPU_REQ = 1'b1; CPU_RW = 1'b1; CPU_SEL = 2'b00;
        for (int k = 1; k <= 6; k++) begin
            tick(); #1;
            chk($sformatf("t1_read_k%0d", k), v1, exp1[k]);
            if (k == 5) CPU_REQ = 1'b0;
        end

        // Both requesters held from reset: alternation DMA, CPU, DMA, CPU
        RST = 1'b1;
        DMA_REQ = 1'b1; DMA_DIR = 1'b0; CPU_REQ = 1'b1; CPU_RW = 1'b0; CPU_SEL = 2'b01;
        tick(); tick();
        RST = 1'b0;
        n_ack = 0;
        for (int k = 1; k <= 26; k++) begin
            tick(); #1;
            chk("t2_select_onehot", ($countones({CSS_O, CSX0_O, CSX1_O, DACK_O}) <= 1), 1'b1);
            chk("t2_strobe_excl", RE_O & WE_O, 1'b0);
            if (k == 3) chk("t2_dma_read_strobe", v1, 11'b10001000010);
            if (k == 9) chk("t2_cpu_write_strobe", v1, 11'b10000101000);
            if (DMA_ACK || CPU_ACK) begin
                if (n_ack < 8) begin
                    ack_k[n_ack]   = k;
                    ack_dma[n_ack] = DMA_ACK;
                end
                n_ack++;
            end
            if (k == 23) begin
                DMA_REQ = 1'b0;
                CPU_REQ = 1'b0;
            end
        end
        chk("t2_ack_count", n_ack, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_ack%0d_cycle", i), ack_k[i], 5 + 6 * i);
            chk($sformatf("t2_ack%0d_owner_dma", i), ack_dma[i], (i % 2 == 0));
        end

        // CPU write to port 2, IORDY low on the last strobe cycle and 3 more
        CPU_REQ = 1'b1; CPU_RW = 1'b0; CPU_SEL = 2'b10;
        we_n = 0; latch_n = 0; csx1_n = 0; ack_at = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            IORDY = (k < 4 || k > 7);
            #1;
            we_n    += int'(WE_O);
            latch_n += int'(LATCH_O);
            csx1_n  += int'(CSX1_O);
            if (CPU_ACK) begin
                ack_at  = k;
                CPU_REQ = 1'b0;
            end
            if (k == 10) chk("t3_idle_after", v1, 11'b0);
        end
        chk("t3_we_width", we_n, 7);
        chk("t3_no_latch", latch_n, 0);
        chk("t3_csx1_width", csx1_n, 9);
        chk("t3_ack_cycle", ack_at, 9);

        // Reset during a DMA read strobe, then tie resolves to DMA
        IORDY = 1'b1;
        DMA_REQ = 1'b1; DMA_DIR = 1'b0;
        dack_at = 0; ack_at = 0;
        for (int k = 1; k <= 15; k++) begin
            tick(); #1;
            if (k == 2) begin
                chk("t4_dma_strobe", v1, 11'b10001000010);
                RST = 1'b1;
                CPU_REQ = 1'b1; CPU_RW = 1'b1; CPU_SEL = 2'b00;
            end
            if (k == 3) begin
                chk("t4_reset_outputs", v1, 11'b0);
                RST = 1'b0;
            end
            if (k == 4) chk("t4_tie_to_dma", v1, 11'b10000000010);
            if (DMA_ACK) begin
                if (dack_at == 0) dack_at = k;
                DMA_REQ = 1'b0;
            end
            if (CPU_ACK) begin
                if (ack_at == 0) ack_at = k;
                CPU_REQ = 1'b0;
            end
        end
        chk("t4_dma_ack_cycle", dack_at, 8);
        chk("t4_cpu_ack_cycle", ack_at, 14);

        // CPU read of port 1 with IORDY held low for a long time
        CPU_REQ = 1'b1; CPU_RW = 1'b1; CPU_SEL = 2'b01;
        ack_at = 0; latch_at = 0; to_at = 0;
        for (int k = 1; k <= 42; k++) begin
            tick();
            IORDY = (k >= 40);
            #1;
`ifdef PPORT_TIMEOUT_EN
            if (k == 39) chk("t5_idle_after_abort", v1, 11'b0);
`else
            if (k == 39) chk("t5_still_waiting", v1, 11'b10001001000);
`endif
            if (LATCH_O && latch_at == 0) latch_at = k;
            if (TIMEOUT_O && to_at == 0) to_at = k;
            if (CPU_ACK) begin
                if (ack_at == 0) ack_at = k;
                CPU_REQ = 1'b0;
            end
        end
`ifdef PPORT_TIMEOUT_EN
        chk("t5_timeout_cycle", to_at, 12);
        chk("t5_no_latch", latch_at, 0);
        chk("t5_ack_cycle", ack_at, 13);
`else
        chk("t5_no_timeout", to_at, 0);
        chk("t5_latch_cycle", latch_at, 40);
        chk("t5_ack_cycle", ack_at, 41);
`endif

        // No-select read on the 2/1/2 instance
        IORDY = 1'b1;
        cpu_req2 = 1'b1; cpu_rw2 = 1'b1; cpu_sel2 = 2'b11;
        for (int k = 1; k <= 6; k++) begin
            tick(); #1;
            chk($sformatf("t6_nosel_k%0d", k), v2, exp6[k]);
            if (k == 5) cpu_req2 = 1'b0;
        end
        chk("t6_main_idle", v1, 11'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pport_arbiter.md
Name: pport_arbiter

Overview:
- Sequences and shares the 8/16-bit peripheral port (WD33C93A port 0, expansion ports 1 and 2) between CPU register accesses and DMA byte transfers.
- Grants one requester at a time, then drives chip-select, read/write strobes, DACK and a read-data latch pulse with parameterised setup/strobe/hold timing, stretched by IORDY.
- Sits between the register/CPU request logic and the top-level pin drivers.
- All outputs are active-high; the top level inverts them onto _IOR, _IOW, _CSS, _CSX0, _CSX1 and _DACK.

Parameters:
- SETUP_CYC, 1: cycles CS is asserted before the strobe (legal range 1..15).
- STROBE_CYC, 3: minimum strobe width in cycles (legal range 1..15).
- HOLD_CYC, 1: cycles CS is held after the strobe (legal range 1..15).
- TIMEOUT_CYC, 255: maximum number of IORDY wait cycles (used only with the optional feature).
- Any value outside its legal range is an elaboration error.

Ports:
- SCLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- CPU_REQ  in  1  CPU peripheral-access request; held until CPU_ACK.
- CPU_RW  in  1  1 = read, 0 = write; sampled at grant.
- CPU_SEL  in  2  00 = port 0 (CSS), 01 = port 1 (CSX0), 10 = port 2 (CSX1), 11 = no CS (cycle runs, no select).
- CPU_ACK  out  1  one-cycle pulse marking completion of a CPU cycle.
- DMA_REQ  in  1  qualified DREQ (DMA enabled and request present).
- DMA_DIR  in  1  1 = memory to SCSI (write), 0 = SCSI to memory (read); sampled at grant.
- DMA_ACK  out  1  one-cycle pulse marking completion of a DMA byte.
- IORDY  in  1  device ready, already synchronous to SCLK.
- RE_O  out  1  read strobe.
- WE_O  out  1  write strobe.
- CSS_O  out  1  port 0 chip-select.
- CSX0_O  out  1  port 1 chip-select.
- CSX1_O  out  1  port 2 chip-select.
- DACK_O  out  1  DMA acknowledge to the device.
- LATCH_O  out  1  one-cycle pulse; the datapath captures PD on this cycle (read cycles only).
- BUSY  out  1  high in every state except IDLE.
- TIMEOUT_O  out  1  one-cycle pulse when an IORDY wait is aborted.

Behaviour:
- Reset: on a rising SCLK edge with RST = 1 the state goes to IDLE and every output is 0. The last-grant flag is set to CPU, so DMA wins the first tie.
- This holds even mid-cycle: strobes and chip-selects drop on that edge, and no ACK is issued.
- States are IDLE, SETUP, STROBE, WAIT_RDY and HOLD. One 4-bit down-counter serves all timed states.
- IDLE: requests are sampled here only.
  - If only one requester is active, that requester is granted.
  - If both are active, the requester that was not granted last wins (alternation, so neither can starve).
  - On grant, latch the owner, the direction and the select, load SETUP_CYC and go to SETUP.
- SETUP: assert the selected CS; for a DMA owner assert DACK_O instead of any CS. On expiry load STROBE_CYC and go to STROBE.
- STROBE: keep CS/DACK asserted and assert RE_O or WE_O according to direction.
  - On the final counted cycle, go to HOLD if IORDY = 1, else go to WAIT_RDY.
  - When going to HOLD on a read, pulse LATCH_O on that final cycle.
- WAIT_RDY: keep the strobe asserted. When IORDY is 1, pulse LATCH_O (reads only) and go to HOLD.
- HOLD: strobe is deasserted, CS/DACK still asserted for HOLD_CYC cycles. The final HOLD cycle pulses CPU_ACK or DMA_ACK (owner only), then the state returns to IDLE.
- Timing with defaults and IORDY = 1: request seen at edge N.
  - CS high in cycles N+1..N+5.
  - RE/WE high in cycles N+2..N+4.
  - LATCH_O high in cycle N+4.
  - ACK high in cycle N+5; IDLE in cycle N+6.
- Throughput: IDLE always lasts at least 1 cycle, so back-to-back transfers cost SETUP_CYC + STROBE_CYC + HOLD_CYC + 1 cycles.
- A request dropped before grant is withdrawn. A request dropped after grant is ignored: the cycle completes and the ACK still pulses.
- RE_O and WE_O are never both high. At most one of CSS_O, CSX0_O, CSX1_O and DACK_O is high.
- CPU_SEL = 11 runs the full timing with all selects low and still ACKs.

Optional Feature:
- Macro PPORT_TIMEOUT_EN.
- When defined: a second 8-bit counter loads TIMEOUT_CYC on entry to WAIT_RDY.
  - On expiry with IORDY still 0, pulse TIMEOUT_O, suppress LATCH_O and go to HOLD; the ACK still pulses.
- When undefined: WAIT_RDY waits indefinitely and TIMEOUT_O is tied to 0.

Decomposition:
- Package pport_pkg holds:
  - the state enum;
  - the CPU_SEL encodings (SEL_PORT0, SEL_PORT1, SEL_PORT2, SEL_NONE);
  - owner encodings (OWN_CPU, OWN_DMA);
  - default timing constants.
- Sub-module pport_timer: a loadable down-counter with a load, a value and a one-cycle expired flag. It is instantiated once, and a second time under PPORT_TIMEOUT_EN.

Test Plan:
- CPU read of port 0, defaults, IORDY = 1, request at edge 10 -> CSS_O high in cycles 11..15, RE_O high 12..14, LATCH_O at 14, CPU_ACK at 15, BUSY low at 16.
- DMA_REQ and CPU_REQ both held from reset -> grants run DMA, CPU, DMA, CPU; each ACK lands 6 cycles apart; DACK_O is never high together with a CS.
- CPU write to port 2 with IORDY low for 4 cycles after the strobe minimum -> WE_O is high for 7 cycles; no LATCH_O; CPU_ACK after one HOLD cycle.
- RST asserted during STROBE of a DMA read -> all outputs 0 on the next edge, no DMA_ACK; after release, the first pending tie goes to DMA.
- With PPORT_TIMEOUT_EN and TIMEOUT_CYC = 8, IORDY stuck low -> TIMEOUT_O pulses 8 cycles after WAIT_RDY entry, no LATCH_O, ACK still issued; without the macro, BUSY stays high indefinitely.
- CPU_SEL = 11 read with SETUP_CYC = 2, STROBE_CYC = 1, HOLD_CYC = 2 -> no select asserted, RE_O high for 1 cycle, CPU_ACK 5 cycles after grant.
